// File: rtl/core_preempt_unit.sv
// core_preempt_unit: services decoder preempt requests (load/store, memory-mapped
// stdin/stdout, jump redirect, halt). Holds busy_o while an access is outstanding.
module core_preempt_unit #(
  parameter logic [7:0] IO_ADDR = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_lsu_en_i,
  input  logic        req_lsu_wen_i,
  input  logic        req_lsu_kind_i,
  input  logic        req_jump_en_i,
  input  logic        req_jump_kind_i,
  input  logic        req_halt_i,
  input  logic [7:0]  addr_i,
  input  logic [3:0]  rd_idx_i,
  input  logic [15:0] rd_val_i,
  input  logic [15:0] rt_val_i,
  output logic        mem_req_o,
  output logic        mem_wen_o,
  output logic [7:0]  mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [15:0] mem_rdata_i,
  input  logic        stdin_valid_i,
  output logic        stdin_ready_o,
  input  logic [15:0] stdin_data_i,
  output logic        stdout_valid_o,
  input  logic        stdout_ready_i,
  output logic [15:0] stdout_data_o,
  output logic        wb_en_o,
  output logic [3:0]  wb_idx_o,
  output logic [15:0] wb_data_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        redirect_o,
  output logic [7:0]  redirect_pc_o,
  output logic        halted_o
);

  // state      | meaning
  // S_IDLE     | accepting requests
  // S_MEM_REQ  | memory request held until granted
  // S_MEM_WAIT | load granted, waiting for read data
  // S_IO_IN    | waiting for a stdin word
  // S_IO_OUT   | offering a stdout word
  // S_WB       | one-cycle completion / write-back
  // S_HALTED   | halted until reset
  typedef enum logic [2:0] {
    S_IDLE, S_MEM_REQ, S_MEM_WAIT, S_IO_IN, S_IO_OUT, S_WB, S_HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        redirect_q, redirect_d;
  logic [7:0]  redirect_pc_q, redirect_pc_d;

  logic [7:0]  eff_addr;
  logic        rt_hi_unused;

  assign eff_addr     = req_lsu_kind_i ? addr_i : rt_val_i[7:0];
  // Only the low byte of R[t] forms an address.
  assign rt_hi_unused = ^rt_val_i[15:8];

  // State and operand registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wen_q         <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wen_q         <= wen_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Next-state selection; halt outranks jump, jump outranks load/store.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_halt_i) begin
          state_d = S_HALTED;
        end else if (req_jump_en_i) begin
          state_d = S_IDLE;
        end else if (req_lsu_en_i) begin
          if (eff_addr == IO_ADDR) state_d = req_lsu_wen_i ? S_IO_OUT : S_IO_IN;
          else                     state_d = S_MEM_REQ;
        end
      end
      S_MEM_REQ:  if (mem_gnt_i)      state_d = wen_q ? S_WB : S_MEM_WAIT;
      S_MEM_WAIT: if (mem_rvalid_i)   state_d = S_WB;
      S_IO_IN:    if (stdin_valid_i)  state_d = S_WB;
      S_IO_OUT:   if (stdout_ready_i) state_d = S_WB;
      S_WB:       state_d = S_IDLE;
      S_HALTED:   state_d = S_HALTED;
      default:    state_d = S_IDLE;
    endcase
  end

  // Operand capture at acceptance, read data capture at completion of the access.
  always_comb begin
    addr_d        = addr_q;
    wen_d         = wen_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (!req_halt_i && req_jump_en_i) begin
          redirect_d    = 1'b1;
          redirect_pc_d = req_jump_kind_i ? addr_i : rd_val_i[7:0];
        end else if (!req_halt_i && req_lsu_en_i) begin
          addr_d  = eff_addr;
          wen_d   = req_lsu_wen_i;
          idx_d   = rd_idx_i;
          wdata_d = rd_val_i;
        end
      end
      S_MEM_WAIT: if (mem_rvalid_i)  rdata_d = mem_rdata_i;
      S_IO_IN:    if (stdin_valid_i) rdata_d = stdin_data_i;
      default: ;
    endcase
  end

  // Outputs decoded from the current state; data buses come straight from the latches.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_wen_o      = 1'b0;
    stdin_ready_o  = 1'b0;
    stdout_valid_o = 1'b0;
    wb_en_o        = 1'b0;
    done_o         = 1'b0;
    busy_o         = 1'b1;
    halted_o       = 1'b0;
    unique case (state_q)
      S_IDLE:    busy_o = 1'b0;
      S_MEM_REQ: begin
        mem_req_o = 1'b1;
        mem_wen_o = wen_q;
      end
      S_MEM_WAIT: ;
      S_IO_IN:   stdin_ready_o  = 1'b1;
      S_IO_OUT:  stdout_valid_o = 1'b1;
      S_WB: begin
        done_o  = 1'b1;
        wb_en_o = !wen_q && (idx_q != 4'd0);
      end
      S_HALTED: begin
        busy_o   = 1'b0;
        halted_o = 1'b1;
      end
      default: busy_o = 1'b0;
    endcase
  end

  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign stdout_data_o = wdata_q;
  assign wb_idx_o      = idx_q;
  assign wb_data_o     = rdata_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_core_preempt_unit.sv
// Bench for core_preempt_unit: a transaction-level model of the outstanding
// operation is checked against the DUT every cycle, plus directed literal checks.
module tb_core_preempt_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_en, lsu_wen, lsu_kind, jmp_en, jmp_kind, halt;
  logic [7:0]  addr;
  logic [3:0]  rd_idx;
  logic [15:0] rd_val, rt_val;
  logic        mem_req, mem_wen, mem_gnt, mem_rvalid;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        stdin_valid, stdin_ready, stdout_valid, stdout_ready;
  logic [15:0] stdin_data, stdout_data;
  logic        wb_en, done, busy, redirect, halted;
  logic [3:0]  wb_idx;
  logic [15:0] wb_data;
  logic [7:0]  redirect_pc;

  always #5 clk = ~clk;

  core_preempt_unit dut (
    .clk_i(clk), .rst_i(rst),
    .req_lsu_en_i(lsu_en), .req_lsu_wen_i(lsu_wen), .req_lsu_kind_i(lsu_kind),
    .req_jump_en_i(jmp_en), .req_jump_kind_i(jmp_kind), .req_halt_i(halt),
    .addr_i(addr), .rd_idx_i(rd_idx), .rd_val_i(rd_val), .rt_val_i(rt_val),
    .mem_req_o(mem_req), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .stdin_valid_i(stdin_valid), .stdin_ready_o(stdin_ready), .stdin_data_i(stdin_data),
    .stdout_valid_o(stdout_valid), .stdout_ready_i(stdout_ready), .stdout_data_o(stdout_data),
    .wb_en_o(wb_en), .wb_idx_o(wb_idx), .wb_data_o(wb_data),
    .done_o(done), .busy_o(busy), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .halted_o(halted)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model of the single outstanding operation
  bit          m_active, m_wen, m_halted, m_granted, m_served;
  logic [7:0]  m_addr, m_redir_pc;
  logic [15:0] m_wdata, m_rdata;
  logic [3:0]  m_idx;
  int          m_redir_cyc = -1;

  // observation records
  int          n_done, n_wb, n_redir, n_req, n_xfer, done_cyc;
  logic [7:0]  last_req_addr, last_redir_pc;
  logic [15:0] last_req_wdata, last_xfer, last_wb_data;
  logic [3:0]  last_wb_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge, release at +1.
  task automatic cycle();
    bit s_req, s_done, s_in, s_out;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_active));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("done_and_redirect", 32'(done & redirect), 32'd0);
    chk("redirect", 32'(redirect), 32'(cyc == m_redir_cyc));
    if (redirect) chk("redirect_pc", 32'(redirect_pc), 32'(m_redir_pc));
    if (mem_req) begin
      chk("mem_req_legal", 32'(m_active && m_addr != 8'hFF && !m_granted), 32'd1);
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wen", 32'(mem_wen), 32'(m_wen));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    if (stdout_valid) begin
      chk("stdout_legal", 32'(m_active && m_wen && m_addr == 8'hFF && !m_served), 32'd1);
      chk("stdout_data", 32'(stdout_data), 32'(m_wdata));
    end
    if (stdin_ready)
      chk("stdin_legal", 32'(m_active && !m_wen && m_addr == 8'hFF && !m_served), 32'd1);
    if (done) chk("done_legal", 32'(m_active && m_served), 32'd1);
    chk("wb_en", 32'(wb_en), 32'(done && !m_wen && m_idx != 4'd0));
    if (wb_en) begin
      chk("wb_idx", 32'(wb_idx), 32'(m_idx));
      chk("wb_data", 32'(wb_data), 32'(m_rdata));
    end
    if (mem_req) begin n_req++; last_req_addr = mem_addr; last_req_wdata = mem_wdata; end
    if (stdout_valid && stdout_ready) begin n_xfer++; last_xfer = stdout_data; end
    if (wb_en) begin n_wb++; last_wb_idx = wb_idx; last_wb_data = wb_data; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (redirect) begin n_redir++; last_redir_pc = redirect_pc; end
    s_req = mem_req; s_done = done; s_in = stdin_ready; s_out = stdout_valid;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_active = 0; m_halted = 0; m_redir_cyc = -1;
    end else if (!m_active && !m_halted) begin
      if (halt) m_halted = 1;
      else if (jmp_en) begin
        m_redir_cyc = cyc;
        m_redir_pc  = jmp_kind ? addr : rd_val[7:0];
      end else if (lsu_en) begin
        m_active = 1; m_granted = 0; m_served = 0;
        m_addr = lsu_kind ? addr : rt_val[7:0];
        m_wen = lsu_wen; m_idx = rd_idx; m_wdata = rd_val;
      end
    end else if (m_active) begin
      if (s_done) m_active = 0;
      else if (m_addr == 8'hFF) begin
        if (!m_wen && s_in && stdin_valid) begin m_served = 1; m_rdata = stdin_data; end
        if (m_wen && s_out && stdout_ready) m_served = 1;
      end else if (s_req && mem_gnt) begin
        m_granted = 1;
        if (m_wen) m_served = 1;
      end else if (m_granted && !m_wen && !m_served && mem_rvalid) begin
        m_served = 1; m_rdata = mem_rdata;
      end
    end
    #1;
  endtask

  task automatic issue_lsu(input bit kind, input bit wen, input logic [7:0] a,
                           input logic [3:0] idx, input logic [15:0] rdv, input logic [15:0] rtv);
    lsu_en = 1; lsu_kind = kind; lsu_wen = wen; addr = a; rd_idx = idx; rd_val = rdv; rt_val = rtv;
    cycle();
    lsu_en = 0;
  endtask

  int a0, d0, w0, r0, q0, x0;

  task automatic snap();
    d0 = n_done; w0 = n_wb; r0 = n_redir; q0 = n_req; x0 = n_xfer;
  endtask

  initial begin
    rst = 1; lsu_en = 0; lsu_wen = 0; lsu_kind = 0; jmp_en = 0; jmp_kind = 0; halt = 0;
    addr = 0; rd_idx = 0; rd_val = 0; rt_val = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    stdin_valid = 0; stdin_data = 0; stdout_ready = 0;
    n_done = 0; n_wb = 0; n_redir = 0; n_req = 0; n_xfer = 0; done_cyc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset values
    @(negedge clk);
    chk("rst_flags", {23'd0, mem_req, mem_wen, stdin_ready, stdout_valid, wb_en, done, busy, redirect, halted}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    chk("rst_stdout_data", 32'(stdout_data), 32'd0);
    @(posedge clk); #1;

    // direct load, memory answers 2 cycles after grant
    snap();
    issue_lsu(1, 0, 8'h10, 4'd3, 16'h1111, 16'h2222);
    mem_gnt = 1; cycle(); mem_gnt = 0;
    cycle(); cycle();
    mem_rvalid = 1; mem_rdata = 16'hBEEF; cycle(); mem_rvalid = 0;
    cycle(); cycle();
    chk("load_done_cnt", n_done - d0, 1);
    chk("load_wb_cnt", n_wb - w0, 1);
    chk("load_wb_idx", 32'(last_wb_idx), 32'd3);
    chk("load_wb_data", 32'(last_wb_data), 32'hBEEF);

    // indirect store, grant held off 3 cycles
    snap();
    issue_lsu(0, 1, 8'h00, 4'd5, 16'h00AA, 16'h1234);
    repeat (3) cycle();
    mem_gnt = 1; cycle(); mem_gnt = 0;
    cycle(); cycle();
    chk("store_req_cycles", n_req - q0, 4);
    chk("store_addr", 32'(last_req_addr), 32'h34);
    chk("store_wdata", 32'(last_req_wdata), 32'h00AA);
    chk("store_done_cnt", n_done - d0, 1);
    chk("store_wb_cnt", n_wb - w0, 0);

    // zero-wait load latency
    a0 = cyc;
    issue_lsu(1, 0, 8'h20, 4'd7, 16'h0, 16'h0);
    mem_gnt = 1; cycle(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 16'h1357; cycle(); mem_rvalid = 0;
    cycle(); cycle();
    chk("load_latency", done_cyc - a0, 3);
    chk("load_data_zw", 32'(last_wb_data), 32'h1357);

    // zero-wait store latency
    a0 = cyc;
    issue_lsu(1, 1, 8'h21, 4'd1, 16'h5A5A, 16'h0);
    mem_gnt = 1; cycle(); mem_gnt = 0;
    cycle(); cycle();
    chk("store_latency", done_cyc - a0, 2);

    // stdin load, input arrives 5 cycles late
    snap();
    issue_lsu(1, 0, 8'hFF, 4'd2, 16'h0, 16'h0);
    repeat (5) cycle();
    stdin_valid = 1; stdin_data = 16'h0007; cycle(); stdin_valid = 0;
    cycle(); cycle();
    chk("in_wb_data", 32'(last_wb_data), 32'h0007);
    chk("in_wb_idx", 32'(last_wb_idx), 32'd2);
    chk("in_no_mem", n_req - q0, 0);

    // stdout store, consumer stalls 2 cycles
    snap();
    issue_lsu(0, 1, 8'h00, 4'd6, 16'h0042, 16'h00FF);
    repeat (2) cycle();
    stdout_ready = 1; cycle(); stdout_ready = 0;
    cycle(); cycle();
    chk("out_xfers", n_xfer - x0, 1);
    chk("out_data", 32'(last_xfer), 32'h0042);
    chk("out_no_mem", n_req - q0, 0);
    chk("out_done_cnt", n_done - d0, 1);
    chk("out_wb_cnt", n_wb - w0, 0);

    // register jump, then immediate jump racing an lsu request
    snap();
    jmp_en = 1; jmp_kind = 0; rd_val = 16'hFF20; cycle(); jmp_en = 0;
    cycle(); cycle();
    chk("jump_cnt", n_redir - r0, 1);
    chk("jump_pc", 32'(last_redir_pc), 32'h20);
    jmp_en = 1; jmp_kind = 1; addr = 8'h9C; lsu_en = 1; lsu_kind = 1; cycle();
    jmp_en = 0; lsu_en = 0;
    cycle(); cycle();
    chk("jump2_pc", 32'(last_redir_pc), 32'h9C);
    chk("jump2_no_mem", n_req - q0, 0);

    // stray rvalid while idle
    snap();
    mem_rvalid = 1; mem_rdata = 16'hCAFE; cycle(); cycle(); mem_rvalid = 0;
    chk("stray_rvalid_done", n_done - d0, 0);

    // load into R0
    snap();
    issue_lsu(1, 0, 8'h30, 4'd0, 16'h0, 16'h0);
    mem_gnt = 1; cycle(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 16'h4444; cycle(); mem_rvalid = 0;
    cycle(); cycle();
    chk("r0_done_cnt", n_done - d0, 1);
    chk("r0_wb_cnt", n_wb - w0, 0);

    // reset during MEM_WAIT, late rvalid ignored
    snap();
    issue_lsu(1, 0, 8'h40, 4'd4, 16'h0, 16'h0);
    mem_gnt = 1; cycle(); mem_gnt = 0;
    cycle();
    rst = 1; cycle(); rst = 0;
    mem_rvalid = 1; mem_rdata = 16'hDEAD; cycle(); mem_rvalid = 0;
    cycle(); cycle();
    chk("abort_done_cnt", n_done - d0, 0);
    chk("abort_wb_cnt", n_wb - w0, 0);
    chk("abort_busy", 32'(busy), 32'd0);

    // halt beats jump and lsu, then everything is ignored until reset
    snap();
    halt = 1; jmp_en = 1; jmp_kind = 1; lsu_en = 1; lsu_kind = 1; addr = 8'h50; cycle();
    halt = 0;
    repeat (3) cycle();
    jmp_en = 0; lsu_en = 0;
    cycle();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_no_redirect", n_redir - r0, 0);
    chk("halt_no_mem", n_req - q0, 0);
    chk("halt_no_done", n_done - d0, 0);
    rst = 1; cycle(); rst = 0;
    cycle();
    chk("halt_cleared", 32'(halted), 32'd0);

    // service resumes after reset
    snap();
    issue_lsu(1, 1, 8'h60, 4'd9, 16'h7777, 16'h0);
    mem_gnt = 1; cycle(); mem_gnt = 0;
    cycle(); cycle();
    chk("resume_done_cnt", n_done - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
